// File: rtl/axi_timer_pkg.sv
// Shared constants and types for the axi_timer peripheral.
// Register offsets, CTRL bit positions, bus FSM states and strobe merge.
package axi_timer_pkg;

  localparam int MEM_W = 32;

  localparam logic [2:0] TMR_CTRL   = 3'd0;
  localparam logic [2:0] TMR_STATUS = 3'd1;
  localparam logic [2:0] TMR_COUNT  = 3'd2;
  localparam logic [2:0] TMR_CMP    = 3'd3;
  localparam logic [2:0] TMR_PRESC  = 3'd4;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WACK  = 2'd1,
    S_RACK  = 2'd2,
    S_RDATA = 2'd3
  } tmr_state_e;

  function automatic logic [MEM_W-1:0] strb_merge(
    input logic [MEM_W-1:0] old_v,
    input logic [MEM_W-1:0] new_v,
    input logic [3:0]       strb
  );
    logic [MEM_W-1:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_timer_core.sv
// Timer datapath: prescaler, 32-bit counter, compare, sticky flag.
// Each register has its own write enable; byte strobes applied here.
module axi_timer_core
  import axi_timer_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ctrl_we,
  input  logic               status_we,
  input  logic               count_we,
  input  logic               cmp_we,
  input  logic               presc_we,
  input  logic [MEM_W-1:0]   wdata,
  input  logic [3:0]         wstrb,
  output logic [2:0]         ctrl_o,
  output logic               flag_o,
  output logic [MEM_W-1:0]   count_o,
  output logic [MEM_W-1:0]   cmp_o,
  output logic [PRESC_W-1:0] presc_o,
  output logic               irq_o
);

  logic [2:0]         ctrl_q, ctrl_d;
  logic               flag_q, flag_d;
  logic [MEM_W-1:0]   count_q, count_d;
  logic [MEM_W-1:0]   cmp_q, cmp_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] psc_q, psc_d;
  logic               tick;
  logic               hit;

  always_comb begin
    tick = ctrl_q[CTRL_EN] && (psc_q == presc_q);
    hit  = tick && (count_q == cmp_q);

    psc_d = '0;
    if (ctrl_q[CTRL_EN] && !tick) psc_d = psc_q + 1'b1;

    // Bus write overrides whatever the tick computed.
    count_d = count_q;
    if (tick) begin
      if (hit && ctrl_q[CTRL_AUTO_RELOAD]) count_d = '0;
      else count_d = count_q + 32'd1;
    end
    if (count_we) count_d = strb_merge(count_q, wdata, wstrb);

    // A match in the same cycle as a clear keeps the flag set.
    flag_d = flag_q;
    if (status_we && wstrb[0] && wdata[0]) flag_d = 1'b0;
    if (hit) flag_d = 1'b1;

    ctrl_d = ctrl_q;
    if (ctrl_we && wstrb[0]) ctrl_d = wdata[2:0];

    cmp_d = cmp_q;
    if (cmp_we) cmp_d = strb_merge(cmp_q, wdata, wstrb);

    presc_d = presc_q;
    if (presc_we) begin
      for (int b = 0; b < PRESC_W; b++) begin
        if (wstrb[b/8]) presc_d[b] = wdata[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      flag_q  <= 1'b0;
      count_q <= '0;
      cmp_q   <= '0;
      presc_q <= '0;
      psc_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      flag_q  <= flag_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      presc_q <= presc_d;
      psc_q   <= psc_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign flag_o  = flag_q;
  assign count_o = count_q;
  assign cmp_o   = cmp_q;
  assign presc_o = presc_q;
  assign irq_o   = flag_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/axi_timer.sv
// AXI4-Lite (AW/W/AR/R) responder wrapping the timer core.
// Bus FSM with registered handshakes and the register read mux.
module axi_timer
  import axi_timer_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MEM_W-1:0] tmr_axi_awaddr,
  input  logic             tmr_axi_awvalid,
  output logic             tmr_axi_awready,
  input  logic [MEM_W-1:0] tmr_axi_wdata,
  input  logic [3:0]       tmr_axi_wstrb,
  input  logic             tmr_axi_wvalid,
  output logic             tmr_axi_wready,
  input  logic [MEM_W-1:0] tmr_axi_araddr,
  input  logic             tmr_axi_arvalid,
  output logic             tmr_axi_arready,
  output logic [MEM_W-1:0] tmr_axi_rdata,
  output logic             tmr_axi_rvalid,
  input  logic             tmr_axi_rready,
  output logic             tmr_irq_o
);

  tmr_state_e         state_q;
  logic               awready_q;
  logic               wready_q;
  logic               arready_q;
  logic               rvalid_q;
  logic [MEM_W-1:0]   rdata_q;

  logic               wr_en;
  logic [2:0]         wr_off;
  logic [2:0]         rd_off;
  logic [MEM_W-1:0]   rd_val;

  logic [2:0]         ctrl;
  logic               flag;
  logic [MEM_W-1:0]   count;
  logic [MEM_W-1:0]   cmp;
  logic [PRESC_W-1:0] presc;

  logic unused_addr;
  assign unused_addr = ^{tmr_axi_awaddr[31:5], tmr_axi_awaddr[1:0],
                         tmr_axi_araddr[31:5], tmr_axi_araddr[1:0]};

  // Address and data are still held by the master during WACK/RACK.
  assign wr_en  = (state_q == S_WACK);
  assign wr_off = tmr_axi_awaddr[4:2];
  assign rd_off = tmr_axi_araddr[4:2];

  axi_timer_core #(
    .PRESC_W(PRESC_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctrl_we  (wr_en && (wr_off == TMR_CTRL)),
    .status_we(wr_en && (wr_off == TMR_STATUS)),
    .count_we (wr_en && (wr_off == TMR_COUNT)),
    .cmp_we   (wr_en && (wr_off == TMR_CMP)),
    .presc_we (wr_en && (wr_off == TMR_PRESC)),
    .wdata    (tmr_axi_wdata),
    .wstrb    (tmr_axi_wstrb),
    .ctrl_o   (ctrl),
    .flag_o   (flag),
    .count_o  (count),
    .cmp_o    (cmp),
    .presc_o  (presc),
    .irq_o    (tmr_irq_o)
  );

  always_comb begin
    rd_val = '0;
    case (rd_off)
      TMR_CTRL:   rd_val = {29'd0, ctrl};
      TMR_STATUS: rd_val = {31'd0, flag};
      TMR_COUNT:  rd_val = count;
      TMR_CMP:    rd_val = cmp;
      TMR_PRESC:  rd_val = MEM_W'(presc);
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (tmr_axi_awvalid && tmr_axi_wvalid) begin
            state_q   <= S_WACK;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end else if (tmr_axi_arvalid) begin
            state_q   <= S_RACK;
            arready_q <= 1'b1;
          end
        end
        S_WACK: state_q <= S_IDLE;
        S_RACK: begin
          state_q  <= S_RDATA;
          rvalid_q <= 1'b1;
          rdata_q  <= rd_val;
        end
        S_RDATA: begin
          if (tmr_axi_rready) begin
            state_q  <= S_IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tmr_axi_awready = awready_q;
  assign tmr_axi_wready  = wready_q;
  assign tmr_axi_arready = arready_q;
  assign tmr_axi_rvalid  = rvalid_q;
  assign tmr_axi_rdata   = rdata_q;

endmodule

// File: doc/axi_timer.md
# axi_timer

Memory-mapped timer peripheral that acts as a responder on one slave port of the AXI4-Lite interconnect: the simplified port with AW/W/AR/R channels only, no B channel and no response codes. It provides a prescaled 32-bit up-counter, a compare register, a sticky match flag, optional auto-reload and a level interrupt toward the core's external-trap input. It sits beside the SRAM as a peripheral on a free interconnect slave port.

## Interface
- `PRESC_W`, 16, width of the prescaler register and counter
- `clk` in 1 system clock, all logic on rising edge
- `rst_n` in 1 reset, synchronous, active-low
- `tmr_axi_awaddr` in `MemAddrBus` (32) write address; only bits [4:2] decoded
- `tmr_axi_awvalid` in 1 write address valid
- `tmr_axi_awready` out 1 write address accepted
- `tmr_axi_wdata` in `MemBus` (32) write data
- `tmr_axi_wstrb` in 4 byte strobes
- `tmr_axi_wvalid` in 1 write data valid
- `tmr_axi_wready` out 1 write data accepted
- `tmr_axi_araddr` in `MemAddrBus` (32) read address; bits [4:2] decoded
- `tmr_axi_arvalid` in 1 read address valid
- `tmr_axi_arready` out 1 read address accepted
- `tmr_axi_rdata` out `MemBus` (32) read data
- `tmr_axi_rvalid` out 1 read data valid
- `tmr_axi_rready` in 1 read data taken
- `tmr_irq_o` out 1 interrupt, level, = `flag & ctrl[1]`

## Operation
- Register map, offset = addr[4:2]:
  - 0 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD; other bits read 0.
  - 1 STATUS: bit0 FLAG, write 1 to clear.
  - 2 COUNT: read/write.
  - 3 CMP: read/write.
  - 4 PRESC: [PRESC_W-1:0] read/write.
  - 5–7: reads return 0; writes are ignored and still acknowledged.
- Byte strobes apply per byte to CTRL, COUNT, CMP and PRESC. For STATUS only wstrb[0] matters.
- Bus FSM states: IDLE, WACK, RACK, RDATA. All handshake outputs are registered and decoded from the state.
  - IDLE → WACK when `awvalid & wvalid`. Write has priority over a simultaneous read.
  - IDLE → RACK when `arvalid` and no write is pending.
  - WACK: `awready = wready = 1` for one cycle. The register updates at the end of this cycle. Next state is IDLE.
  - RACK: `arready = 1` for one cycle. `rdata` is captured from the register at the end of this cycle. Next state is RDATA.
  - RDATA: `rvalid = 1` and `rdata` are held stable until `rready`. Return to IDLE on the cycle `rvalid & rready`.
- Counter:
  - While EN=1, `psc` increments each cycle.
  - When `psc == PRESC`, a tick occurs and `psc` returns to 0. PRESC=0 therefore gives one tick per cycle.
  - EN=0 holds COUNT and forces `psc` to 0.
- On a tick:
  - If COUNT == CMP: FLAG is set to 1, and COUNT becomes 0 if AUTO_RELOAD, else COUNT+1.
  - Otherwise COUNT becomes COUNT+1, wrapping modulo 2^32 (0xFFFFFFFF → 0).
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick: the write wins.
  - A write-1-clear of FLAG in the same cycle as a set: the set wins.
  - A CMP write takes effect for the next tick.

## Timing
- Reset values: all registers 0, `psc` 0, FSM IDLE, so that every output is 0 (`rdata` = 0, `irq_o` = 0).
- Write latency: the cycle after AW and W are both valid, `awready`/`wready` pulse for one cycle. The new value is visible the following cycle.
- Read latency: `arready` on cycle N+1 after `arvalid` at N, `rvalid` from N+2. Minimum 3 cycles per read transaction.
- Masters must hold their valids until accepted. The slave never asserts ready in IDLE.
- `irq_o` rises one cycle after the tick that sets FLAG. It falls one cycle after the clearing write is accepted.
- Reset asserted mid-transaction, in any state, returns to IDLE with all outputs 0 on the next edge; a pending `rvalid` is dropped.

## Structure
- Shared package/defines: register offset constants (TMR_CTRL=3'd0 … TMR_PRESC=3'd4), CTRL bit indices, FSM state encoding.
- One sub-module is natural: `axi_timer_core` (prescaler, counter, compare, flag), with a write-enable/strobe input per register. The bus FSM and register decode stay in `axi_timer`.

## Test plan
- Reset, then read all offsets 0–7 → every `rdata` = 0, `irq_o` = 0, ready and valid signals low throughout reset.
- Write CMP=5, PRESC=0, CTRL=0x3 → FLAG=1 and `irq_o` rises one cycle after the tick where COUNT==5. COUNT reads 6 after that tick and keeps incrementing.
- AUTO_RELOAD: CMP=3, PRESC=2, CTRL=0x7 → COUNT sequence 0,1,2,3,0 with one tick every 3 cycles. FLAG set on each wrap. Write STATUS=1 → `irq_o` falls one cycle after acceptance.
- Wrap: write COUNT=0xFFFFFFFF, CMP=0x10, EN=1 → COUNT=0 after the next tick, FLAG stays 0.
- Collision checks:
  - Same-cycle `awvalid`/`wvalid`/`arvalid` → write served first, read follows.
  - COUNT write coinciding with a tick → the written value is read back.
  - FLAG clear coinciding with a set → FLAG=1.
- Byte strobes and backpressure:
  - Write CMP=0xAABBCCDD with wstrb=4'b0101 over CMP=0 → CMP reads 0x00BB00DD.
  - Hold `rready` low for 10 cycles → `rvalid` and `rdata` stay stable.
